sprite_motion_ctrl: RTL and testbench

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/sprite_motion_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Moves NUM_SPRITES sprites by STEP pixels per axis once per frame, bouncing
// them off the edges of the visible area, and arbitrates the per-sprite pixel
// streams into one output pixel (lowest index wins).
// Optional feature: define SPRITE_COLLISION_DETECT_EN to enable overlap
// detection; without it the collision output is tied low.
module sprite_motion_ctrl #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int STEP        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic                      enable,
  input  logic                      pause,
  input  logic [NUM_SPRITES-1:0]    drawing_in,
  input  logic [NUM_SPRITES-1:0]    color_in,
  output logic [NUM_SPRITES*10-1:0] sprite_x,
  output logic [NUM_SPRITES*10-1:0] sprite_y,
  output logic                      drawing_out,
  output logic                      color_out,
  output logic                      collision,
  output logic [15:0]               frame_count,
  output logic                      busy
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPRITES - 1);
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPRITE_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_UPDATE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // One axis step with bounce. Returns {direction_negative, new_position}.
  // The sum is done in 11-bit signed so a step past zero is seen as negative.
  function automatic logic [10:0] axis_step(input logic [9:0] pos,
                                            input logic       neg,
                                            input logic [9:0] lim);
    logic signed [10:0] cur;
    logic signed [10:0] nxt;
    logic [10:0]        res;
    cur = $signed({1'b0, pos});
    if (neg) begin
      nxt = cur - STEP_S;
    end else begin
      nxt = cur + STEP_S;
    end
    if (nxt < 11'sd0) begin
      res = {1'b0, 10'd0};
    end else if (nxt > $signed({1'b0, lim})) begin
      res = {1'b1, lim};
    end else begin
      res = {neg, nxt[9:0]};
    end
    return res;
  endfunction

  // vsync synchronizer and edge-detect history
  logic vs_meta_q;
  logic vs_sync_q;
  logic vs_last_q;
  logic vs_fall_s;

  // controller state
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_count_q, frame_count_d;

  // sprite positions and directions (dir = 1 means moving toward 0)
  logic [9:0] x_q   [NUM_SPRITES];
  logic [9:0] x_d   [NUM_SPRITES];
  logic [9:0] y_q   [NUM_SPRITES];
  logic [9:0] y_d   [NUM_SPRITES];
  logic       dxn_q [NUM_SPRITES];
  logic       dxn_d [NUM_SPRITES];
  logic       dyn_q [NUM_SPRITES];
  logic       dyn_d [NUM_SPRITES];

  // Bring the asynchronous vsync into the clock domain and keep one more
  // sample so a synchronized high-to-low transition can be seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_last_q <= 1'b0;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_last_q <= vs_sync_q;
    end
  end

  assign vs_fall_s = vs_last_q & ~vs_sync_q;

  // Next-state logic: frame sequencing, sprite index and registered busy.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT_VS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_VS: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (vs_fall_s) begin
          state_d = S_UPDATE;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = S_WAIT_VS;
        end
      end
      S_UPDATE: begin
        // The sprite addressed this cycle is always updated; dropping
        // enable only prevents the next one from starting.
        if (!enable) begin
          state_d = S_IDLE;
          idx_d   = {IDX_W{1'b0}};
        end else if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = S_UPDATE;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        frame_count_d = frame_count_q + 16'd1;
        if (enable) begin
          state_d = S_WAIT_VS;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
    busy_d = (state_d == S_UPDATE);
  end

  // Sprite motion: only the sprite addressed in an UPDATE cycle moves, and
  // only while not paused; every other case holds position and direction.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      dxn_d[i] = dxn_q[i];
      dyn_d[i] = dyn_q[i];
    end
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if ((state_q == S_UPDATE) && !pause && (idx_q == IDX_W'(i))) begin
        {dxn_d[i], x_d[i]} = axis_step(x_q[i], dxn_q[i], X_MAX);
        {dyn_d[i], y_d[i]} = axis_step(y_q[i], dyn_q[i], Y_MAX);
      end else begin
        x_d[i]   = x_q[i];
        y_d[i]   = y_q[i];
        dxn_d[i] = dxn_q[i];
        dyn_d[i] = dyn_q[i];
      end
    end
  end

  // Controller FSM and sprite state registers; reset abandons any update
  // sequence in progress and restores the starting layout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= {IDX_W{1'b0}};
      busy_q        <= 1'b0;
      frame_count_q <= 16'd0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]   <= 10'(20 + 100 * i);
        y_q[i]   <= 10'(20 + 60 * i);
        dxn_q[i] <= 1'b0;
        dyn_q[i] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        dxn_q[i] <= dxn_d[i];
        dyn_q[i] <= dyn_d[i];
      end
    end
  end

  // Pack the per-sprite position registers onto the output buses.
  always_comb begin
    sprite_x = '0;
    sprite_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sprite_x[10*i +: 10] = x_q[i];
      sprite_y[10*i +: 10] = y_q[i];
    end
  end

  // Pixel arbitration: any sprite drawing lights the pixel, the lowest
  // index drawing sprite supplies the colour (scan high to low so it wins).
  always_comb begin
    drawing_out = |drawing_in;
    color_out   = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (drawing_in[i]) begin
        color_out = color_in[i];
      end else begin
        color_out = color_out;
      end
    end
  end

  assign frame_count = frame_count_q;
  assign busy        = busy_q;

`ifdef SPRITE_COLLISION_DETECT_EN
  logic multi_s;
  logic seen_s;
  logic col_flag_q, col_flag_d;
  logic collision_q, collision_d;

  // Overlap detect: two or more sprites drawing the same pixel.
  always_comb begin
    multi_s = 1'b0;
    seen_s  = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      multi_s = multi_s | (seen_s & drawing_in[i]);
      seen_s  = seen_s | drawing_in[i];
    end
  end

  // Sticky per-frame flag; at frame end it is published and restarted, with
  // an overlap seen in that same cycle carried into the next frame.
  always_comb begin
    if (state_q == S_DONE) begin
      collision_d = col_flag_q;
      col_flag_d  = multi_s;
    end else begin
      collision_d = collision_q;
      col_flag_d  = col_flag_q | multi_s;
    end
  end

  // Collision flag and published collision registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_flag_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      col_flag_q  <= col_flag_d;
      collision_q <= collision_d;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl
// Self-checking bench: a behavioural frame model runs beside the DUT and is
// compared with it every cycle; directed scenarios pin the model with
// hand-computed values. Collision expectations follow SPRITE_COLLISION_DETECT_EN.
module tb_sprite_motion_ctrl;

  localparam int N   = 4;
  localparam int SW  = 32;
  localparam int SH  = 32;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int STP = 2;
`ifdef SPRITE_COLLISION_DETECT_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            vsync = 1'b1;
  logic            enable = 1'b0;
  logic            pause = 1'b0;
  logic [N-1:0]    drawing_in = '0;
  logic [N-1:0]    color_in = '0;
  logic [N*10-1:0] sprite_x;
  logic [N*10-1:0] sprite_y;
  logic            drawing_out;
  logic            color_out;
  logic            collision;
  logic [15:0]     frame_count;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sprite_motion_ctrl #(
    .NUM_SPRITES(N), .SPRITE_W(SW), .SPRITE_H(SH),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .STEP(STP)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .enable(enable), .pause(pause),
    .drawing_in(drawing_in), .color_in(color_in),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .drawing_out(drawing_out), .color_out(color_out),
    .collision(collision), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ph: -1 idle, 0 waiting for frame start, 1..N moving sprite ph-1, N+1 frame end
  int mx[N], my[N];
  bit mdxn[N], mdyn[N];
  int ph;
  int mfc;
  bit mcol, mflag;
  bit s0, s1, s2;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 20 + 100 * i;
      my[i] = 20 + 60 * i;
      mdxn[i] = 1'b0;
      mdyn[i] = 1'b0;
    end
    ph = -1; mfc = 0; mcol = 1'b0; mflag = 1'b0;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
  endtask

  task automatic move(input int i);
    int nx, ny;
    nx = mx[i] + (mdxn[i] ? -STP : STP);
    ny = my[i] + (mdyn[i] ? -STP : STP);
    if (nx < 0) begin mx[i] = 0; mdxn[i] = 1'b0; end
    else if (nx > HA - SW) begin mx[i] = HA - SW; mdxn[i] = 1'b1; end
    else mx[i] = nx;
    if (ny < 0) begin my[i] = 0; mdyn[i] = 1'b0; end
    else if (ny > VA - SH) begin my[i] = VA - SH; mdyn[i] = 1'b1; end
    else my[i] = ny;
  endtask

  task automatic model_step();
    bit fall, multi;
    fall  = s2 && !s1;
    multi = ($countones(drawing_in) >= 2);
    if (ph == -1) begin
      ph = enable ? 0 : -1;
    end else if (ph == 0) begin
      ph = !enable ? -1 : (fall ? 1 : 0);
    end else if (ph <= N) begin
      if (!pause) move(ph - 1);
      ph = !enable ? -1 : ((ph == N) ? N + 1 : ph + 1);
    end else begin
      mfc = (mfc + 1) % 65536;
      if (COL_EN) begin mcol = mflag; mflag = 1'b0; end
      ph = enable ? 0 : -1;
    end
    if (COL_EN && multi) mflag = 1'b1;
    s2 = s1; s1 = s0; s0 = vsync;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Compare DUT against the model every cycle, just after the clock edge.
  initial begin
    logic [N*10-1:0] ex, ey;
    logic ecol;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          ex[10*i +: 10] = 10'(mx[i]);
          ey[10*i +: 10] = 10'(my[i]);
        end
        ecol = 1'b0;
        for (int i = N - 1; i >= 0; i--) if (drawing_in[i]) ecol = color_in[i];
        chk("cyc_x", 64'(sprite_x), 64'(ex));
        chk("cyc_y", 64'(sprite_y), 64'(ey));
        chk("cyc_busy", 64'(busy), 64'((ph >= 1) && (ph <= N)));
        chk("cyc_fc", 64'(frame_count), 64'(mfc));
        chk("cyc_col", 64'(collision), 64'(mcol));
        chk("cyc_draw", 64'(drawing_out), 64'(|drawing_in));
        chk("cyc_color", 64'(color_out), 64'(ecol));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_frame(output int bc);
    bc = 0;
    @(negedge clk); vsync = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy) bc++;
    end
    @(negedge clk); vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [N*10-1:0] rst_x, rst_y;

  initial begin
    int bc, t;
    rst_x = {10'd320, 10'd220, 10'd120, 10'd20};
    rst_y = {10'd200, 10'd140, 10'd80, 10'd20};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    // reset state
    chk("rst_x", 64'(sprite_x), 64'(rst_x));
    chk("rst_y", 64'(sprite_y), 64'(rst_y));
    chk("rst_fc", 64'(frame_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_col", 64'(collision), 64'd0);

    // one frame after enabling
    @(negedge clk); enable = 1'b1;
    repeat (2) @(negedge clk);
    do_frame(bc);
    chk("f1_busy_cycles", 64'(bc), 64'd4);
    chk("f1_x0", 64'(sprite_x[9:0]), 64'd22);
    chk("f1_y0", 64'(sprite_y[9:0]), 64'd22);
    chk("f1_x3", 64'(sprite_x[39:30]), 64'd322);
    chk("f1_y3", 64'(sprite_y[39:30]), 64'd202);
    chk("f1_fc", 64'(frame_count), 64'd1);

    // bounce off the right edge: 608 reached after 294 frames, bounce at 295
    do_reset();
    for (int k = 1; k <= 296; k++) begin
      do_frame(bc);
      if (k == 294) begin
        chk("b294_x0", 64'(sprite_x[9:0]), 64'd608);
        chk("b294_y0", 64'(sprite_y[9:0]), 64'd290);
      end
      if (k == 295) chk("b295_x0", 64'(sprite_x[9:0]), 64'd608);
    end
    chk("b296_x0", 64'(sprite_x[9:0]), 64'd606);
    chk("b296_y0", 64'(sprite_y[9:0]), 64'd286);
    chk("b296_fc", 64'(frame_count), 64'd296);

    // pause over three frames
    @(negedge clk); pause = 1'b1;
    repeat (3) do_frame(bc);
    chk("p_x0", 64'(sprite_x[9:0]), 64'd606);
    chk("p_y0", 64'(sprite_y[9:0]), 64'd286);
    chk("p_fc", 64'(frame_count), 64'd299);
    @(negedge clk); pause = 1'b0;

    // pixel arbitration
    @(negedge clk); drawing_in = 4'b0110; color_in = 4'b0100; #1;
    chk("arb_draw", 64'(drawing_out), 64'd1);
    chk("arb_color", 64'(color_out), 64'd0);
    @(negedge clk); drawing_in = 4'b1000; color_in = 4'b1000; #1;
    chk("arb_hi_color", 64'(color_out), 64'd1);
    @(negedge clk); drawing_in = 4'b0000; color_in = 4'b1111; #1;
    chk("arb_none_draw", 64'(drawing_out), 64'd0);
    chk("arb_none_color", 64'(color_out), 64'd0);

    // collision: flush the overlap above, then one overlap cycle, then clean
    do_frame(bc);
    @(negedge clk); drawing_in = 4'b0011;
    @(negedge clk); drawing_in = 4'b0000;
    do_frame(bc);
    chk("col_set", 64'(collision), 64'(COL_EN));
    do_frame(bc);
    chk("col_clear", 64'(collision), 64'd0);

    // randomized run
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      enable     = ($urandom_range(0, 15) != 0);
      pause      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) vsync = ~vsync;
      drawing_in = 4'($urandom);
      color_in   = 4'($urandom);
    end

    // reset during the second update cycle
    @(negedge clk);
    enable = 1'b1; pause = 1'b0; vsync = 1'b1; drawing_in = '0; color_in = '0;
    repeat (12) @(negedge clk);
    vsync = 1'b0;
    t = 0;
    while (!busy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("r_busy_seen", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("r_second_update", 64'(busy), 64'd1);
    @(negedge clk); reset = 1'b1; #1;
    chk("r_x", 64'(sprite_x), 64'(rst_x));
    chk("r_y", 64'(sprite_y), 64'(rst_y));
    chk("r_fc", 64'(frame_count), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("r_after_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
